rtc_access_scheduler: RTL and testbench

RTC_ACCESS_SCHEDULER -- requirements
Module: rtc_access_scheduler

---
 rtl/rtc_sched_pkg.sv | 38 +++
 rtl/rr_arbiter_3.sv | 39 +++
 rtl/rtc_access_scheduler.sv | 123 ++++++++++++
 tb/tb_rtc_access_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_sched_pkg.sv
// Shared types and helpers for the RTC access scheduler: FSM encoding,
// requester indices and byte-lane selection on the packed request buses.
package rtc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] REQ_CFG = 2'd0;
  localparam logic [1:0] REQ_SEQ = 2'd1;
  localparam logic [1:0] REQ_ALM = 2'd2;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    case (oh)
      3'b010:  return REQ_SEQ;
      3'b100:  return REQ_ALM;
      default: return REQ_CFG;
    endcase
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == REQ_ALM) ? REQ_CFG : idx + 2'd1;
  endfunction

  function automatic logic [7:0] lane8(input logic [23:0] bus, input logic [1:0] idx);
    case (idx)
      REQ_SEQ: return bus[15:8];
      REQ_ALM: return bus[23:16];
      default: return bus[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_3.sv
// Three-way round-robin pick: the first requester found when scanning
// upward from i_ptr (wrapping) wins; output is one-hot or all-zero.
module rr_arbiter_3
  import rtc_sched_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_pick
);

  logic [2:0] w_rot;
  logic [2:0] w_first;

  // Rotate so the pointer position lands on bit 0, take a fixed-priority
  // pick, then rotate the result back.
  always_comb begin
    case (i_ptr)
      REQ_SEQ: w_rot = {i_req[0], i_req[2], i_req[1]};
      REQ_ALM: w_rot = {i_req[1], i_req[0], i_req[2]};
      default: w_rot = i_req;
    endcase
  end

  always_comb begin
    w_first = 3'b000;
    if (w_rot[0])      w_first = 3'b001;
    else if (w_rot[1]) w_first = 3'b010;
    else if (w_rot[2]) w_first = 3'b100;
  end

  always_comb begin
    case (i_ptr)
      REQ_SEQ: o_pick = {w_first[1], w_first[0], w_first[2]};
      REQ_ALM: o_pick = {w_first[0], w_first[2], w_first[1]};
      default: o_pick = w_first;
    endcase
  end

endmodule

// File: rtl/rtc_access_scheduler.sv
// Arbitrates three RTC requesters onto one bus engine with round-robin
// fairness, optional bus lock, and a WAIT-state timeout that aborts with 8'hFF.
module rtc_access_scheduler
  import rtc_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_wr,
  output logic [2:0]  gnt,
  output logic [2:0]  done_o,
  output logic [7:0]  rdata_o,
  output logic        timeout_o,
  output logic        eng_start,
  output logic [7:0]  eng_addr,
  output logic [7:0]  eng_data,
  output logic        eng_wr,
  input  logic        eng_done,
  input  logic [7:0]  eng_rdata
);

  localparam logic [10:0] TMO_LAST = 11'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [10:0] r_cnt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_owner;
  logic        r_locked;

  logic [2:0]  w_pick;
  logic [1:0]  w_pick_idx;

  rr_arbiter_3 u_arb (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick)
  );

  assign w_pick_idx = onehot_to_idx(w_pick);

  // NOTE: every output is a register written only here with <=, so pulses
  // are glitch-free and the synchronous reset covers all state in one place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ptr     <= REQ_CFG;
      r_owner   <= REQ_CFG;
      r_locked  <= 1'b0;
      gnt       <= '0;
      done_o    <= '0;
      rdata_o   <= '0;
      timeout_o <= 1'b0;
      eng_start <= 1'b0;
      eng_addr  <= '0;
      eng_data  <= '0;
      eng_wr    <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      done_o    <= '0;
      timeout_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_locked) begin
            // A locked grant serves only its holder until the lock falls.
            if (!(|(lock & gnt))) begin
              gnt      <= '0;
              r_locked <= 1'b0;
              r_ptr    <= next_idx(r_owner);
            end else if (|(req & gnt)) begin
              eng_addr <= lane8(req_addr, r_owner);
              eng_data <= lane8(req_data, r_owner);
              eng_wr   <= |(req_wr & gnt);
              r_state  <= ST_START;
            end
          end else if (|req) begin
            gnt      <= w_pick;
            r_owner  <= w_pick_idx;
            eng_addr <= lane8(req_addr, w_pick_idx);
            eng_data <= lane8(req_data, w_pick_idx);
            eng_wr   <= |(req_wr & w_pick);
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          eng_start <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            rdata_o <= eng_rdata;
            done_o  <= gnt;
            r_state <= ST_DONE;
          end else if (r_cnt == TMO_LAST) begin
            rdata_o   <= 8'hFF;
            done_o    <= gnt;
            timeout_o <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end
        ST_DONE: begin
          if (|(lock & gnt)) begin
            r_locked <= 1'b1;
          end else begin
            gnt   <= '0;
            r_ptr <= next_idx(r_owner);
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Randomized scoreboard bench for rtc_access_scheduler: a behavioural
// arbitration model predicts each completion; a monitor checks done_o pulses.
module tb_rtc_access_scheduler;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, lock, req_wr;
  logic [23:0] req_addr, req_data;
  logic [2:0]  gnt, done_o;
  logic [7:0]  rdata_o;
  logic        timeout_o, eng_start;
  logic [7:0]  eng_addr, eng_data;
  logic        eng_wr, eng_done;
  logic [7:0]  eng_rdata;

  rtc_access_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_wr    (req_wr),
    .gnt       (gnt),
    .done_o    (done_o),
    .rdata_o   (rdata_o),
    .timeout_o (timeout_o),
    .eng_start (eng_start),
    .eng_addr  (eng_addr),
    .eng_data  (eng_data),
    .eng_wr    (eng_wr),
    .eng_done  (eng_done),
    .eng_rdata (eng_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] done_v;
    logic [7:0] rdata;
    logic       tmo;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Engine plan for the transaction in flight: 0 answer after p_lat,
  // 1 silent, 2 silent then a stale eng_done in the DONE cycle.
  int         p_mode = 0;
  int         p_lat  = 1;
  logic [7:0] p_rdata, p_addr, p_data;
  logic       p_wr;
  int         start_cyc = 0;

  // Reference model: rotating pointer and current lock holder (-1 = none).
  int m_ptr  = 0;
  int m_lock = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic finish_report();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic int model_pick(input logic [2:0] r);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  // Bus engine model.
  initial begin
    int w;
    eng_done  = 1'b0;
    eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        start_cyc = cyc;
        check("eng_addr", eng_addr, p_addr);
        check("eng_data", eng_data, p_data);
        check("eng_wr", eng_wr, p_wr);
        if (p_mode != 1) begin
          w = (p_mode == 2) ? TMO : p_lat;
          repeat (w) @(negedge clk);
          eng_done  = 1'b1;
          eng_rdata = (p_mode == 2) ? ~p_rdata : p_rdata;
          if (p_mode == 0) check("eng_addr_hold", eng_addr, p_addr);
          @(negedge clk);
          eng_done  = 1'b0;
          eng_rdata = 8'($urandom);
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && done_o !== 3'b000) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_o", done_o, e.done_v);
          check("rdata_o", rdata_o, e.rdata);
          check("timeout_o", timeout_o, e.tmo);
          check("done_latency", cyc - start_cyc, e.lat);
        end
      end else if (timeout_o !== 1'b0) begin
        check("timeout_without_done", 32'(timeout_o), 32'd0);
      end
    end
  end

  task automatic run_txn(input logic [2:0] rv, input logic [2:0] lv, input logic [23:0] addr,
                         input logic [23:0] data, input logic [2:0] wr, input int mode,
                         input int lat, input logic [7:0] rd, input bit drop, input bit chk_lat);
    int w;
    int n;
    logic [2:0] rv2;
    exp_t e;
    rv2 = rv;
    if (m_lock >= 0 && !lv[m_lock]) begin
      m_ptr  = (m_lock + 1) % 3;
      m_lock = -1;
    end
    if (m_lock >= 0) begin
      w = m_lock;
      rv2[w] = 1'b1;
    end else begin
      w = model_pick(rv2);
    end
    e.done_v = 3'b001 << w;
    e.rdata  = (mode == 0) ? rd : 8'hFF;
    e.tmo    = (mode != 0);
    e.lat    = (mode == 0) ? lat + 1 : TMO;
    sb.push_back(e);
    p_mode  = mode;
    p_lat   = lat;
    p_rdata = rd;
    p_addr  = 8'(addr >> (8 * w));
    p_data  = 8'(data >> (8 * w));
    p_wr    = |(wr & e.done_v);
    if (lv[w]) m_lock = w;
    else       m_ptr  = (w + 1) % 3;
    req_addr = addr;
    req_data = data;
    req_wr   = wr;
    lock     = lv;
    req      = rv2;
    if (chk_lat) begin
      @(negedge clk);
      check("gnt_at_cycle1", gnt, e.done_v);
      @(negedge clk);
      check("eng_start_at_cycle2", 32'(eng_start), 32'd1);
    end
    n = 0;
    while (done_o === 3'b000) begin
      @(negedge clk);
      n++;
      if (drop && eng_start === 1'b1) req = req & ~e.done_v;
      if (n > 60) begin
        total++;
        bad++;
        $display("FAIL txn_wait: no done_o after %0d cycles, expected one", n);
        finish_report();
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_txn(input logic [2:0] rv, input logic [2:0] lv, input int mode, input int lat);
    run_txn(rv, lv, 24'($urandom), 24'($urandom), 3'($urandom), mode, lat, 8'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_report();
  end

  initial begin
    int n;
    int mode;
    logic [2:0] rv, lv;
    reset = 1'b1; req = '0; lock = '0; req_wr = '0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done_o, 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_eng_addr", eng_addr, 0);
    check("rst_eng_data", eng_data, 0);
    check("rst_eng_wr", 32'(eng_wr), 0);
    check("rst_rdata", rdata_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read from the sequencer, minimum-latency timing checked.
    run_txn(3'b010, 3'b000, 24'h00_21_00, 24'h5A_5A_5A, 3'b000, 0, 3, 8'h45, 1'b0, 1'b1);

    // Contention: all three held; order follows the rotating pointer.
    for (int i = 0; i < 4; i++) rand_txn(3'b111, 3'b000, 0, $urandom_range(1, 7));

    // Lock: requester 1 holds the bus for 9 reads while 0 keeps requesting.
    for (int i = 0; i < 9; i++)
      run_txn(3'b011, 3'b010, 24'($urandom), 24'($urandom), 3'b000, 0, $urandom_range(1, 4),
              8'($urandom), 1'b0, 1'b0);
    rand_txn(3'b001, 3'b000, 0, 2);

    // Timeout boundaries: silent, coincident eng_done, stale late eng_done, minimum.
    rand_txn(3'b100, 3'b000, 1, 1);
    rand_txn(3'b001, 3'b000, 0, TMO - 1);
    rand_txn(3'b010, 3'b000, 2, 1);
    rand_txn(3'b100, 3'b000, 0, 1);

    // Owner drops req mid-transaction; completion still arrives.
    run_txn(3'b011, 3'b000, 24'($urandom), 24'($urandom), 3'b111, 0, 4, 8'($urandom), 1'b1, 1'b0);

    // Reset during WAIT aborts silently and clears the pointer.
    p_mode = 1; p_lat = 1; p_rdata = 8'h00;
    req_addr = 24'($urandom); req_data = 24'($urandom); req_wr = 3'b100; lock = 3'b000;
    p_addr = req_addr[23:16]; p_data = req_data[23:16]; p_wr = 1'b1;
    req = 3'b100;
    n = 0;
    while (eng_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("eng_start_before_reset", 32'(eng_start), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req = 3'b000;
    @(negedge clk);
    check("midrst_gnt", gnt, 0);
    check("midrst_eng_addr", eng_addr, 0);
    check("midrst_eng_wr", 32'(eng_wr), 0);
    check("midrst_rdata", rdata_o, 0);
    reset = 1'b0;
    m_ptr = 0;
    m_lock = -1;
    repeat (12) @(negedge clk);
    rand_txn(3'b111, 3'b000, 0, 2);

    // Randomized traffic with occasional locks, timeouts and idle gaps.
    for (int i = 0; i < 40; i++) begin
      rv   = 3'($urandom_range(1, 7));
      lv   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      n    = $urandom_range(0, 9);
      mode = (n == 0) ? 1 : (n == 1) ? 2 : 0;
      run_txn(rv, lv, 24'($urandom), 24'($urandom), 3'($urandom), mode, $urandom_range(1, 7),
              8'($urandom), ($urandom_range(0, 4) == 0) && (mode == 0), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        req = 3'b000;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end

    req = 3'b000;
    lock = 3'b000;
    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    finish_report();
  end

endmodule
